// File: rtl/clock_pkg.sv
// Shared definitions for the time-set controller: session states,
// display field-select codes, field limits and small field helpers.
package clock_pkg;

    // Session states; S_YEAR..S_SEC share their encoding with field_sel.
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_YEAR   = 3'd1,
        ST_MON    = 3'd2,
        ST_DAY    = 3'd3,
        ST_HOUR   = 3'd4,
        ST_MIN    = 3'd5,
        ST_SEC    = 3'd6,
        ST_COMMIT = 3'd7
    } state_t;

    // Display field-select codes.
    localparam logic [2:0] FS_NONE   = 3'd0;
    localparam logic [2:0] FS_YEAR   = 3'd1;
    localparam logic [2:0] FS_MONTH  = 3'd2;
    localparam logic [2:0] FS_DAY    = 3'd3;
    localparam logic [2:0] FS_HOUR   = 3'd4;
    localparam logic [2:0] FS_MINUTE = 3'd5;
    localparam logic [2:0] FS_SECOND = 3'd6;

    // Field limits (day maximum is a module parameter).
    localparam logic [7:0] FIELD_ZERO = 8'd0;
    localparam logic [7:0] YEAR_MAX   = 8'd99;
    localparam logic [7:0] MONTH_MIN  = 8'd1;
    localparam logic [7:0] MONTH_MAX  = 8'd12;
    localparam logic [7:0] DAY_MIN    = 8'd1;
    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    // Increment with wrap; anything at or above the maximum goes to the minimum.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        return (v >= hi) ? lo : v + 8'd1;
    endfunction

    // Force an out-of-range snapshot value to the field minimum.
    function automatic logic [7:0] clamp_field(input logic [7:0] v,
                                               input logic [7:0] lo,
                                               input logic [7:0] hi);
        return ((v < lo) || (v > hi)) ? lo : v;
    endfunction

    // Order in which the mode button walks through the edit states.
    function automatic state_t next_state(input state_t s);
        case (s)
            ST_YEAR: return ST_MON;
            ST_MON:  return ST_DAY;
            ST_DAY:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            ST_MIN:  return ST_SEC;
            ST_SEC:  return ST_COMMIT;
            default: return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button rise detector with optional hold-to-repeat.
// Repeat logic is only active when CLOCK_SET_AUTO_REPEAT_EN is defined and
// the instance has REPEAT_EN set; otherwise the counter stays at zero.
module btn_edge #(
    parameter bit REPEAT_EN  = 1'b0,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_rep_en,
    output logic o_pulse
);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam bit REP_ON = REPEAT_EN;
`else
    localparam bit REP_ON = 1'b0;
`endif
    localparam int RMAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int RW   = $clog2(RMAX + 1);

    logic          r_prev;
    logic [RW-1:0] r_rep_cnt;
    logic          r_armed;
    logic          w_rise;
    logic          w_held;
    logic          w_rep_hit;

    assign w_rise    = i_btn & ~r_prev;
    assign w_held    = i_btn & r_prev & i_rep_en & REP_ON;
    assign w_rep_hit = r_armed ? (r_rep_cnt == RW'(REPEAT_CYC - 1))
                               : (r_rep_cnt == RW'(REPEAT_DLY - 1));
    assign o_pulse   = w_rise | (w_held & w_rep_hit);

    // History register; resets high so a button held through reset gives no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= 1'b1;
        else      r_prev <= i_btn;
    end

    // Hold timer: first repeat after REPEAT_DLY, then every REPEAT_CYC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!w_held) begin
            r_rep_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt <= '0;
            r_armed   <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: snapshot, per-field edit, commit strobe,
// inactivity abort, field-select and blink for the display.
// Optional auto-repeat on the inc button: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DAYS_PER_MONTH = 30,
    parameter int TIMEOUT_CYC    = 50_000_000,
    parameter int BLINK_CYC      = 12_500_000,
    parameter int REPEAT_DLY     = 25_000_000,
    parameter int REPEAT_CYC     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_year,
    input  logic [7:0] cur_month,
    input  logic [7:0] cur_day,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_minute,
    input  logic [7:0] cur_second,
    output logic       set_en,
    output logic       load,
    output logic [7:0] ld_year,
    output logic [7:0] ld_month,
    output logic [7:0] ld_day,
    output logic [7:0] ld_hour,
    output logic [7:0] ld_minute,
    output logic [7:0] ld_second,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic [2:0] dbg_state
);
    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam int         BW       = $clog2(BLINK_CYC + 1);
    localparam logic [7:0] DAY_MAX  = 8'(DAYS_PER_MONTH);

    state_t        r_state;
    logic [7:0]    r_ld_year, r_ld_month, r_ld_day, r_ld_hour, r_ld_minute, r_ld_second;
    logic [TW-1:0] r_tmo;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    logic          w_mode_pulse;
    logic          w_inc_pulse;
    logic          w_editing;

    assign w_editing = (r_state != ST_RUN) && (r_state != ST_COMMIT);

    btn_edge #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)) u_mode (
        .clk(clk), .rst(rst), .i_btn(btn_mode), .i_rep_en(1'b0), .o_pulse(w_mode_pulse)
    );

    btn_edge #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_CYC(REPEAT_CYC)) u_inc (
        .clk(clk), .rst(rst), .i_btn(btn_inc), .i_rep_en(w_editing), .o_pulse(w_inc_pulse)
    );

    // Session FSM with shadow registers and inactivity timer; mode beats inc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_tmo       <= '0;
            r_ld_year   <= '0;
            r_ld_month  <= '0;
            r_ld_day    <= '0;
            r_ld_hour   <= '0;
            r_ld_minute <= '0;
            r_ld_second <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_tmo <= '0;
                    if (w_mode_pulse) begin
                        r_state     <= ST_YEAR;
                        r_ld_year   <= clamp_field(cur_year,   FIELD_ZERO, YEAR_MAX);
                        r_ld_month  <= clamp_field(cur_month,  MONTH_MIN,  MONTH_MAX);
                        r_ld_day    <= clamp_field(cur_day,    DAY_MIN,    DAY_MAX);
                        r_ld_hour   <= clamp_field(cur_hour,   FIELD_ZERO, HOUR_MAX);
                        r_ld_minute <= clamp_field(cur_minute, FIELD_ZERO, MINSEC_MAX);
                        r_ld_second <= clamp_field(cur_second, FIELD_ZERO, MINSEC_MAX);
                    end
                end
                ST_COMMIT: begin
                    r_tmo   <= '0;
                    r_state <= ST_RUN;
                end
                default: begin
                    if (w_mode_pulse) begin
                        r_state <= next_state(r_state);
                        r_tmo   <= '0;
                    end else if (w_inc_pulse) begin
                        r_tmo <= '0;
                        case (r_state)
                            ST_YEAR: r_ld_year   <= wrap_inc(r_ld_year,   FIELD_ZERO, YEAR_MAX);
                            ST_MON:  r_ld_month  <= wrap_inc(r_ld_month,  MONTH_MIN,  MONTH_MAX);
                            ST_DAY:  r_ld_day    <= wrap_inc(r_ld_day,    DAY_MIN,    DAY_MAX);
                            ST_HOUR: r_ld_hour   <= wrap_inc(r_ld_hour,   FIELD_ZERO, HOUR_MAX);
                            ST_MIN:  r_ld_minute <= wrap_inc(r_ld_minute, FIELD_ZERO, MINSEC_MAX);
                            ST_SEC:  r_ld_second <= wrap_inc(r_ld_second, FIELD_ZERO, MINSEC_MAX);
                            default: ;
                        endcase
                    end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                        r_state <= ST_RUN;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
            endcase
        end
    end

    // Blink generator: free-running half-period toggle while not in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_CYC - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Field-select decode of the state register.
    always_comb begin
        field_sel = FS_NONE;
        case (r_state)
            ST_YEAR: field_sel = FS_YEAR;
            ST_MON:  field_sel = FS_MONTH;
            ST_DAY:  field_sel = FS_DAY;
            ST_HOUR: field_sel = FS_HOUR;
            ST_MIN:  field_sel = FS_MINUTE;
            ST_SEC:  field_sel = FS_SECOND;
            default: field_sel = FS_NONE;
        endcase
    end

    assign set_en    = (r_state != ST_RUN);
    assign load      = (r_state == ST_COMMIT);
    assign blink     = r_blink;
    assign dbg_state = r_state;
    assign ld_year   = r_ld_year;
    assign ld_month  = r_ld_month;
    assign ld_day    = r_ld_day;
    assign ld_hour   = r_ld_hour;
    assign ld_minute = r_ld_minute;
    assign ld_second = r_ld_second;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: session-level reference model (field array plus
// selected-field index) driven by directed and random button sequences.
module tb_clock_set_ctrl;
  localparam int DPM    = 30;
  localparam int TMO    = 100;
  localparam int BLK    = 8;
  localparam int RDLY   = 10;
  localparam int RCYC   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b1;
  logic [7:0] cur_v [1:6];
  logic       set_en, load, blink;
  logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second;
  logic [2:0] field_sel, dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: 0 = RUN, 1..6 = editing that field
  int         m_sel = 0;
  logic [7:0] m_fld [1:6];

  int          load_seen = 0;
  logic [47:0] load_val = '0;

  clock_set_ctrl #(
    .DAYS_PER_MONTH(DPM), .TIMEOUT_CYC(TMO), .BLINK_CYC(BLK),
    .REPEAT_DLY(RDLY), .REPEAT_CYC(RCYC)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_year(cur_v[1]), .cur_month(cur_v[2]), .cur_day(cur_v[3]),
    .cur_hour(cur_v[4]), .cur_minute(cur_v[5]), .cur_second(cur_v[6]),
    .set_en(set_en), .load(load),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day),
    .ld_hour(ld_hour), .ld_minute(ld_minute), .ld_second(ld_second),
    .field_sel(field_sel), .blink(blink), .dbg_state(dbg_state)
  );

  // clock / load monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_seen++;
      load_val = {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second};
    end
  end

  function automatic int f_lo(int i);
    return (i == 2 || i == 3) ? 1 : 0;
  endfunction

  function automatic int f_hi(int i);
    case (i)
      1: return 99;
      2: return 12;
      3: return DPM;
      4: return 23;
      default: return 59;
    endcase
  endfunction

  function automatic logic [47:0] m_pack();
    return {m_fld[1], m_fld[2], m_fld[3], m_fld[4], m_fld[5], m_fld[6]};
  endfunction

  function automatic logic [47:0] d_pack();
    return {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second};
  endfunction

  task automatic model_inc();
    if (m_sel >= 1 && m_sel <= 6) begin
      if (int'(m_fld[m_sel]) >= f_hi(m_sel)) m_fld[m_sel] = 8'(f_lo(m_sel));
      else m_fld[m_sel] = m_fld[m_sel] + 8'd1;
    end
  endtask

  // driver tasks: one rising edge each, returning at the negedge after it
  task automatic pulse_mode();
    @(negedge clk); btn_mode = 1'b1;
    @(negedge clk); btn_mode = 1'b0;
  endtask

  task automatic pulse_inc();
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
  endtask

  // mode step with model update and checks (commit verified via load monitor)
  task automatic do_mode();
    if (m_sel == 6) begin
      load_seen = 0;
      pulse_mode();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (load_seen !== 1) begin n_err++; $display("FAIL commit_load_cycles got=%0d exp=1", load_seen); end
      n_cmp++;
      if (load_val !== m_pack()) begin n_err++; $display("FAIL commit_values got=%h exp=%h", load_val, m_pack()); end
      m_sel = 0;
    end else begin
      if (m_sel == 0)
        for (int i = 1; i <= 6; i++)
          m_fld[i] = (int'(cur_v[i]) < f_lo(i) || int'(cur_v[i]) > f_hi(i)) ? 8'(f_lo(i)) : cur_v[i];
      m_sel++;
      pulse_mode();
    end
    n_cmp++;
    if (field_sel !== 3'(m_sel) || set_en !== (m_sel != 0)) begin
      n_err++; $display("FAIL mode_step sel=%0d set_en=%0b exp_sel=%0d", field_sel, set_en, m_sel);
    end
    n_cmp++;
    if (d_pack() !== m_pack()) begin n_err++; $display("FAIL mode_fields got=%h exp=%h", d_pack(), m_pack()); end
  endtask

  task automatic do_inc();
    model_inc();
    pulse_inc();
    n_cmp++;
    if (d_pack() !== m_pack() || field_sel !== 3'(m_sel)) begin
      n_err++; $display("FAIL inc_step got=%h sel=%0d exp=%h sel=%0d", d_pack(), field_sel, m_pack(), m_sel);
    end
  endtask

  task automatic set_cur(int y, int mo, int d, int h, int mi, int s);
    cur_v[1] = 8'(y); cur_v[2] = 8'(mo); cur_v[3] = 8'(d);
    cur_v[4] = 8'(h); cur_v[5] = 8'(mi); cur_v[6] = 8'(s);
  endtask

  task automatic test_reset();
    set_cur(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) m_fld[i] = 8'd0;
    rst = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (set_en !== 1'b0 || field_sel !== 3'd0 || load !== 1'b0 || blink !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs set_en=%0b sel=%0d load=%0b blink=%0b exp all 0", set_en, field_sel, load, blink);
    end
    n_cmp++;
    if (d_pack() !== 48'd0) begin n_err++; $display("FAIL reset_ld got=%h exp=0", d_pack()); end
    n_cmp++;
    if (load_seen !== 0) begin n_err++; $display("FAIL reset_no_load got=%0d exp=0", load_seen); end
  endtask

  task automatic test_snapshot_edit();
    set_cur(24, 5, 17, 13, 45, 30);
    do_mode();
    repeat (3) do_inc();
    n_cmp++;
    if (ld_year !== 8'd27) begin n_err++; $display("FAIL year_plus3 got=%0d exp=27", ld_year); end
    repeat (6) do_mode();
  endtask

  task automatic test_wraps();
    set_cur(99, 12, DPM, 23, 59, 59);
    do_mode();
    for (int f = 1; f <= 6; f++) begin
      do_inc();
      if (f < 6) do_mode();
    end
    n_cmp++;
    if ({ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} !== {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
      n_err++; $display("FAIL wrap_all got=%h exp=000101000000", d_pack());
    end
    do_mode();
  endtask

  task automatic test_sanitise_run_inc();
    set_cur(200, 0, DPM + 1, 24, 60, 255);
    do_mode();
    n_cmp++;
    if (d_pack() !== {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
      n_err++; $display("FAIL sanitise got=%h exp=000101000000", d_pack());
    end
    repeat (6) do_mode();
    // inc in RUN is ignored
    pulse_inc();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (set_en !== 1'b0 || d_pack() !== m_pack()) begin
      n_err++; $display("FAIL run_inc set_en=%0b got=%h exp=%h", set_en, d_pack(), m_pack());
    end
  endtask

  task automatic test_simul_timeout();
    int n;
    int toggles;
    logic pb;
    set_cur(10, 3, 4, 5, 6, 7);
    repeat (5) do_mode();
    @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
    @(negedge clk); btn_mode = 1'b0; btn_inc = 1'b0;
    m_sel = 6;
    n_cmp++;
    if (field_sel !== 3'd6 || ld_minute !== m_fld[5]) begin
      n_err++; $display("FAIL simul_mode_wins sel=%0d min=%0d exp sel=6 min=%0d", field_sel, ld_minute, m_fld[5]);
    end
    load_seen = 0; n = 0; toggles = 0; pb = blink;
    while (set_en === 1'b1 && n < 4 * TMO) begin
      @(negedge clk); n++;
      if (set_en === 1'b1 && blink !== pb) toggles++;
      pb = blink;
    end
    m_sel = 0;
    n_cmp++;
    if (n < TMO - 1 || n > TMO + 1) begin n_err++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO); end
    n_cmp++;
    if (load_seen !== 0) begin n_err++; $display("FAIL timeout_no_load got=%0d exp=0", load_seen); end
    n_cmp++;
    if (toggles < TMO / BLK - 1 || toggles > TMO / BLK + 1) begin
      n_err++; $display("FAIL blink_toggles got=%0d exp=%0d", toggles, TMO / BLK);
    end
    @(negedge clk);
    n_cmp++;
    if (blink !== 1'b0 || field_sel !== 3'd0 || d_pack() !== m_pack()) begin
      n_err++; $display("FAIL after_timeout blink=%0b sel=%0d got=%h exp=%h", blink, field_sel, d_pack(), m_pack());
    end
  endtask

  task automatic test_repeat();
    int n_exp;
    set_cur(1, 1, 1, 1, 1, 0);
    repeat (6) do_mode();
    @(negedge clk); btn_inc = 1'b1;
    repeat (30) @(negedge clk);
    btn_inc = 1'b0;
    n_exp = 1;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    if (30 > RDLY) n_exp = n_exp + 1 + (30 - 1 - RDLY) / RCYC;
`endif
    repeat (n_exp) model_inc();
    @(negedge clk);
    n_cmp++;
    if (ld_second !== m_fld[6]) begin n_err++; $display("FAIL hold_inc got=%0d exp=%0d", ld_second, m_fld[6]); end
    do_mode();
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      for (int i = 1; i <= 6; i++)
        cur_v[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(f_lo(i), f_hi(i)));
      do_mode();
      for (int k = 0; k < 40 && m_sel != 0; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 9) < 7) do_inc();
        else do_mode();
      end
      while (m_sel != 0) do_mode();
    end
  endtask

  // reset mid-session drops straight back to RUN with no strobe
  task automatic test_reset_mid();
    set_cur(5, 6, 7, 8, 9, 10);
    repeat (3) do_mode();
    load_seen = 0;
    @(negedge clk); rst = 1'b0;
    #1;
    n_cmp++;
    if (set_en !== 1'b0 || d_pack() !== 48'd0) begin
      n_err++; $display("FAIL reset_mid set_en=%0b ld=%h exp 0/0", set_en, d_pack());
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (load_seen !== 0) begin n_err++; $display("FAIL reset_mid_load got=%0d exp=0", load_seen); end
    m_sel = 0;
    for (int i = 1; i <= 6; i++) m_fld[i] = 8'd0;
  endtask

  initial begin
    test_reset();
    test_snapshot_edit();
    test_wraps();
    test_sanitise_run_inc();
    test_simul_timeout();
    test_repeat();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
